// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// behind a start/busy/done handshake. A zero divisor finishes immediately with div_by_zero set.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [WIDTH:0]  r_p;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_quot, r_rem;
  logic            r_dbz;

  logic            w_accept;
  logic            w_qbit;
  logic [WIDTH:0]  w_pp, w_t, w_p_next;

  // Dividend bits leave from the top of r_dvd while quotient bits enter at the bottom.
  assign w_pp     = {r_p[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_t      = w_pp - {1'b0, r_dvs};
  assign w_qbit   = ~w_t[WIDTH];
  assign w_p_next = w_qbit ? w_t : w_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (divisor == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (r_cnt == '0) w_state_next = StDone;
      end
      StDone: begin
        done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_p    <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= CntInit;
      r_p   <= '0;
      r_dvd <= dividend;
      r_dvs <= divisor;
      if (divisor == '0) begin
        r_quot <= '1;
        r_rem  <= dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_quot <= '0;
        r_rem  <= '0;
        r_dbz  <= 1'b0;
      end
    end else if (r_state == StRun) begin
      r_cnt <= r_cnt - CntW'(1);
      r_p   <= w_p_next;
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
      if (r_cnt == '0) begin
        r_quot <= {r_dvd[WIDTH-2:0], w_qbit};
        r_rem  <= w_p_next[WIDTH-1:0];
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4): directed cases, exhaustive
// operand sweep and random ops against an arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones / dividend / dbz.
  task automatic model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endtask

  task automatic run_op(input int a, input int b);
    int eq, er, ez, lat, nbusy;
    model(a, b, eq, er, ez);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat   = 0;
    nbusy = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && b != 0) begin
        check_eq("cleared_q", 32'(quotient), 0);
        check_eq("cleared_r", 32'(remainder), 0);
      end
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", lat, (b == 0) ? 1 : W + 1);
    check_eq("busy_width", nbusy, (b == 0) ? 0 : W);
    check_eq("quotient", 32'(quotient), eq);
    check_eq("remainder", 32'(remainder), er);
    check_eq("dbz", 32'(div_by_zero), ez);
    @(negedge clk);
    check_eq("done_width", 32'(done), 0);
    check_eq("q_held", 32'(quotient), eq);
    check_eq("r_held", 32'(remainder), er);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ndone;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_q", 32'(quotient), 0);
    check_eq("rst_r", 32'(remainder), 0);
    check_eq("rst_dbz", 32'(div_by_zero), 0);
    #11;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_done", 32'(done), 0);
    end

    run_op(13, 3);
    run_op(15, 1);
    run_op(2, 7);
    run_op(9, 0);
    run_op(6, 2);

    // start held high: operands wander after accept, re-accept on the first IDLE cycle
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check_eq("hold_done", 32'(done), 1);
        check_eq("hold_q", 32'(quotient), 2);
        check_eq("hold_r", 32'(remainder), 2);
      end
      if (k == 6) begin
        check_eq("hold_idle_busy", 32'(busy), 0);
        check_eq("hold_idle_done", 32'(done), 0);
      end
      if (k == 7) check_eq("hold_reaccept", 32'(busy), 1);
      if (k == 6) begin
        dividend = 4'd7;
        divisor  = 4'd2;
      end else begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check_eq("hold2_seen_done", 32'(lat != 0), 1);
    check_eq("hold2_q", 32'(quotient), 3);
    check_eq("hold2_r", 32'(remainder), 1);
    @(negedge clk);

    // reset during RUN aborts the op
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_q", 32'(quotient), 0);
    check_eq("abort_r", 32'(remainder), 0);
    check_eq("abort_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    run_op(11, 2);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b);
      end
    end

    for (int n = 0; n < 30; n++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
